sign_mag_display_sequencer: RTL and testbench

- Display-source controller for the sign-magnitude adder board design.
- Decides which 8-bit sign-magnitude value goes to the hex/segment display controller: operand A (sw[7:0]), operand B (sw[15:8]) or adder sum.
- Inputs are debounced button levels; the block edge-detects them and keeps the selection in registered state, so the display never falls through to an undefined or latched selection.
- An auto mode rotates A → B → SUM with a programmable dwell time.

---
 rtl/sign_mag_display_sequencer.sv | 112 +++++++++++
 tb/tb_sign_mag_display_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sign_mag_display_sequencer.sv
// Display-source sequencer: edge-detected buttons pick op_a/op_b/sum or an auto A->B->SUM rotation (NEG_ZERO_NORM_EN folds -0 to +0).
// Latency: button rise changes state at the sampling edge, outputs follow one edge later; operand changes show after 1 cycle.
// Backpressure: none; free-running, outputs refresh every cycle.
module sign_mag_display_sequencer #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_lvl,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] sum,
  output logic [7:0] mag,
  output logic       sign,
  output logic [1:0] sel,
  output logic       auto_active
);

  typedef enum logic [1:0] {SHOW_A, SHOW_B, SHOW_SUM, AUTO} state_t;

  localparam logic [1:0] SRC_A   = 2'b00;
  localparam logic [1:0] SRC_B   = 2'b01;
  localparam logic [1:0] SRC_SUM = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       btn_prev;
  logic [2:0]       rise;
  logic [1:0]       cur_src;
  logic [1:0]       sel_d;
  logic [7:0]       v;
  logic             sign_d;

  always_comb begin
    rise    = btn_lvl & ~btn_prev;
    state_d = state_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    if (state_q == AUTO) begin
      if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
        cnt_d = '0;
        case (sub_q)
          SRC_A:   sub_d = SRC_B;
          SRC_B:   sub_d = SRC_SUM;
          default: sub_d = SRC_A;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Any button event overrides the dwell advance computed above.
    case (rise)
      3'b000: ;
      3'b001: begin state_d = SHOW_A;   cnt_d = '0; end
      3'b010: begin state_d = SHOW_B;   cnt_d = '0; end
      3'b100: begin state_d = SHOW_SUM; cnt_d = '0; end
      default: begin
        cnt_d = '0;
        if (state_q == AUTO) begin
          state_d = SHOW_A;
        end else begin
          state_d = AUTO;
          sub_d   = SRC_A;
        end
      end
    endcase
  end

  always_comb begin
    case (state_q)
      SHOW_B:   cur_src = SRC_B;
      SHOW_SUM: cur_src = SRC_SUM;
      AUTO:     cur_src = sub_q;
      default:  cur_src = SRC_A;
    endcase
    case (cur_src)
      SRC_B:   begin v = op_b; sel_d = SRC_B;   end
      SRC_SUM: begin v = sum;  sel_d = SRC_SUM; end
      default: begin v = op_a; sel_d = SRC_A;   end
    endcase
`ifdef NEG_ZERO_NORM_EN
    sign_d = v[7] & (v[6:0] != 7'd0);
`else
    sign_d = v[7];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SHOW_A;
      sub_q       <= SRC_A;
      cnt_q       <= '0;
      btn_prev    <= 3'b000;
      mag         <= 8'h00;
      sign        <= 1'b0;
      sel         <= SRC_A;
      auto_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      btn_prev    <= btn_lvl;
      mag         <= {1'b0, v[6:0]};
      sign        <= sign_d;
      sel         <= sel_d;
      auto_active <= (state_q == AUTO);
    end
  end

endmodule

// File: tb/tb_sign_mag_display_sequencer.sv
// Bench for sign_mag_display_sequencer with a short dwell; model plus directed literal checks.
module tb_sign_mag_display_sequencer;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_lvl;
  logic [7:0] op_a, op_b, sum;
  logic [7:0] mag;
  logic       sign;
  logic [1:0] sel;
  logic       auto_active;

  int n_chk  = 0;
  int n_fail = 0;

  sign_mag_display_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .reset(reset), .btn_lvl(btn_lvl), .op_a(op_a), .op_b(op_b), .sum(sum),
    .mag(mag), .sign(sign), .sel(sel), .auto_active(auto_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0/1/2 = fixed source, 3 = rotating; rotation source derived from cycles since entry.
  int         m_mode = 0;
  int         m_cnt  = 0;
  logic [2:0] m_prev = 3'b000;
  logic [2:0] m_rise;
  int         m_src;
  logic [7:0] m_v;
  logic [7:0] e_mag  = 8'h00;
  logic       e_sign = 1'b0;
  int         e_sel  = 0;
  logic       e_auto = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_cnt = 0; m_prev = 3'b000;
      e_mag = 8'h00; e_sign = 1'b0; e_sel = 0; e_auto = 1'b0;
    end else begin
      m_src  = (m_mode == 3) ? (m_cnt / DWELL) % 3 : m_mode;
      m_v    = (m_src == 0) ? op_a : (m_src == 1) ? op_b : sum;
      e_sel  = m_src;
      e_mag  = {1'b0, m_v[6:0]};
`ifdef NEG_ZERO_NORM_EN
      e_sign = (m_v == 8'h80) ? 1'b0 : m_v[7];
`else
      e_sign = m_v[7];
`endif
      e_auto = (m_mode == 3);
      m_rise = btn_lvl & ~m_prev;
      m_prev = btn_lvl;
      case ($countones(m_rise))
        0: if (m_mode == 3) m_cnt++;
        1: m_mode = m_rise[0] ? 0 : (m_rise[1] ? 1 : 2);
        default: begin
          if (m_mode == 3) m_mode = 0;
          else begin m_mode = 3; m_cnt = 0; end
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("model_mag", mag, e_mag);
      chk("model_sign", sign, e_sign);
      chk("model_sel", sel, e_sel);
      chk("model_auto", auto_active, e_auto);
    end
  end

  initial begin
    reset = 1'b1; btn_lvl = 3'b000;
    op_a = 8'h85; op_b = 8'h13; sum = 8'h00;
    #1 reset = 1'b0;
    #2;
    chk("reset_mag", mag, 8'h00);
    chk("reset_sel", sel, 0);
    chk("reset_auto", auto_active, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_mag", mag, 8'h05);
    chk("post_reset_sign", sign, 1);

    // mid-run async reset while showing B
    btn_lvl = 3'b010;
    @(negedge clk) btn_lvl = 3'b000;
    @(negedge clk);
    chk("pre_reset_sel", sel, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_mag", mag, 8'h00);
    chk("async_sign", sign, 0);
    chk("async_sel", sel, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("release_mag", mag, 8'h05);
    chk("release_sign", sign, 1);
    chk("release_sel", sel, 0);

    // held button: one transition only
    btn_lvl = 3'b010;
    @(negedge clk);
    chk("held_lat_sel", sel, 0);
    @(negedge clk);
    chk("held_sel", sel, 1);
    repeat (8) @(negedge clk);
    chk("held_end_sel", sel, 1);
    chk("held_mag", mag, 8'h13);
    chk("held_sign", sign, 0);
    btn_lvl = 3'b000;

    // SUM source, then op_a change must not leak through
    sum = 8'hFF; btn_lvl = 3'b100;
    @(negedge clk) btn_lvl = 3'b000;
    @(negedge clk);
    chk("sum_sel", sel, 2);
    chk("sum_mag", mag, 8'h7F);
    chk("sum_sign", sign, 1);
    op_a = 8'h22;
    repeat (2) @(negedge clk);
    chk("sum_hold_mag", mag, 8'h7F);

    // AUTO entry via two simultaneous rises, 4-cycle dwell per source
    btn_lvl = 3'b101;
    @(negedge clk) btn_lvl = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("auto_seq_sel", sel, (k - 1) / DWELL);
      chk("auto_seq_act", auto_active, 1);
    end
    repeat (3) @(negedge clk);
    btn_lvl = 3'b010;            // rise lands on a wrap edge
    @(negedge clk) btn_lvl = 3'b000;
    @(negedge clk);
    chk("wrap_btn_sel", sel, 1);
    chk("wrap_btn_auto", auto_active, 0);

    // AUTO exit via 111, re-entry via 011 starts at A with fresh count
    btn_lvl = 3'b011;
    @(negedge clk) btn_lvl = 3'b000;
    repeat (6) @(negedge clk);
    chk("auto2_sel", sel, 1);
    btn_lvl = 3'b111;
    @(negedge clk) btn_lvl = 3'b000;
    @(negedge clk);
    chk("exit_sel", sel, 0);
    chk("exit_auto", auto_active, 0);
    btn_lvl = 3'b011;
    @(negedge clk) btn_lvl = 3'b000;
    @(negedge clk);
    chk("reenter_auto", auto_active, 1);
    chk("reenter_sel", sel, 0);
    repeat (3) @(negedge clk);
    chk("reenter_last_a", sel, 0);
    @(negedge clk);
    chk("reenter_first_b", sel, 1);

    // negative zero on operand A
    btn_lvl = 3'b001; op_a = 8'h80;
    @(negedge clk) btn_lvl = 3'b000;
    @(negedge clk);
    chk("negzero_mag", mag, 8'h00);
    chk("negzero_sel", sel, 0);
`ifdef NEG_ZERO_NORM_EN
    chk("negzero_sign", sign, 0);
`else
    chk("negzero_sign", sign, 1);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
